// File: rtl/cfglut5_ld_if.sv
`default_nettype none
// ============================================================================
// Module   : cfglut5_ld_if
// Brief    : Parallel truth-table load handshake (valid/ready + 32-bit word).
// Revision : 1.0 - initial release
// ============================================================================
interface cfglut5_ld_if;
    logic [31:0] CFG_DATA;
    logic        CFG_VALID;
    logic        CFG_READY;

    modport master (output CFG_DATA, output CFG_VALID, input  CFG_READY);
    modport slave  (input  CFG_DATA, input  CFG_VALID, output CFG_READY);
endinterface
`default_nettype wire

// File: rtl/cfglut5_ld.sv
`default_nettype none
// ============================================================================
// Module   : cfglut5_ld
// Brief    : Reconfigurable 5-input LUT with serial shift-in and an optional
//            parallel loader enabled by macro CFGLUT5_PARLOAD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cfglut5_ld #(
    parameter logic [31:0] INIT = 32'h0000_0000
) (
    input  wire logic   CLK,
    input  wire logic   RSTN,
    input  wire logic   I0,
    input  wire logic   I1,
    input  wire logic   I2,
    input  wire logic   I3,
    input  wire logic   I4,
    input  wire logic   CDI,
    input  wire logic   CE,
    cfglut5_ld_if.slave cfg,
    output logic        O6,
    output logic        O5,
    output logic        CDO,
    output logic        BUSY
);

    logic [31:0] r_table;
    logic [4:0]  w_addr;

    assign w_addr = {I4, I3, I2, I1, I0};
    assign O6     = r_table[w_addr];
    assign O5     = r_table[{1'b0, w_addr[3:0]}];
    assign CDO    = r_table[31];

`ifdef CFGLUT5_PARLOAD_EN
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_shadow;
    logic [4:0]  r_count;

    assign cfg.CFG_READY = (r_state == ST_IDLE);
    assign BUSY          = (r_state == ST_LOAD);

    // The loader replays the shadow word MSB first through the same shift
    // path as serial data, so T passes through every intermediate value.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_table  <= INIT;
            r_shadow <= 32'h0000_0000;
            r_count  <= 5'd0;
            r_state  <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cfg.CFG_VALID) begin
                        r_shadow <= cfg.CFG_DATA;
                        r_count  <= 5'd0;
                        r_state  <= ST_LOAD;
                    end else if (CE) begin
                        r_table <= {r_table[30:0], CDI};
                    end
                end
                ST_LOAD: begin
                    r_table  <= {r_table[30:0], r_shadow[31]};
                    r_shadow <= {r_shadow[30:0], 1'b0};
                    if (r_count == 5'd31) begin
                        r_count <= 5'd0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_count <= r_count + 5'd1;
                    end
                end
                default: begin
                    r_count <= 5'd0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end
`else
    logic w_unused_cfg;

    assign w_unused_cfg  = ^{cfg.CFG_DATA, cfg.CFG_VALID};
    assign cfg.CFG_READY = 1'b0;
    assign BUSY          = 1'b0;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_table <= INIT;
        end else if (CE) begin
            r_table <= {r_table[30:0], CDI};
        end
    end
`endif

endmodule
`default_nettype wire
